bit_count_unit: RTL and testbench

BIT_COUNT_UNIT -- requirements
Module: bit_count_unit

---
 rtl/bit_count_unit.sv | 165 ++++++++++++++++
 tb/tb_bit_count_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_count_unit.sv
// -----------------------------------------------------------------------------
// bit_count_unit
//
// Multi-cycle bit counter for the 2*LEN-bit word W = {i_a, i_b}. Each COUNT
// cycle examines STEP bits, so every operation takes N = 2*LEN/STEP COUNT
// cycles regardless of operand value.
//
// Modes (i_mode):
//   00 : number of zero bits in W
//   01 : number of one bits in W
//   10 : leading zeros  (zeros above the most significant 1)
//   11 : trailing zeros (zeros below the least significant 1)
//
// Ports:
//   i_clk    : clock, rising edge active
//   i_rst_n  : asynchronous active-low reset
//   i_start  : operation request, only sampled while idle
//   i_mode   : operation select (see above), captured at start
//   i_a      : upper half of W (LEN bits), captured at start
//   i_b      : lower half of W (LEN bits), captured at start
//   o_busy   : high while an operation is in COUNT or DONE
//   o_done   : one-cycle pulse while the fresh result is presented
//   o_count  : result bits [LEN-1:0], held until the next result
//   o_carry  : result bit LEN
// -----------------------------------------------------------------------------
module bit_count_unit #(
  parameter int LEN  = 4,
  parameter int STEP = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [1:0]     i_mode,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [LEN-1:0] o_count,
  output logic           o_carry
);

  localparam int WW    = 2 * LEN;
  localparam int N     = WW / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  // LEN+1 bits always covers the maximum count of 2*LEN for LEN >= 2.
  localparam int ACC_W = LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WW-1:0]      r_word;
  logic [1:0]         r_mode;
  logic [ACC_W-1:0]   r_acc;
  logic               r_found;
  logic [CNT_W-1:0]   r_step;
  logic               r_busy;
  logic               r_done;
  logic [LEN-1:0]     r_count;
  logic               r_carry;

  logic [WW-1:0]      w_word_in;
  logic [WW-1:0]      w_word_rev;
  logic [WW-1:0]      w_word_load;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_found_next;
  logic               w_last_step;

  assign w_word_in = {i_a, i_b};

  // Leading-zero mode stores W bit-reversed so that every mode can consume
  // the captured word LSB-first with one shared shifter.
  generate
    for (genvar gi = 0; gi < WW; gi++) begin : g_rev
      assign w_word_rev[gi] = w_word_in[WW-1-gi];
    end
  endgenerate

  assign w_word_load = (i_mode == 2'b10) ? w_word_rev : w_word_in;
  assign w_last_step = (r_step == CNT_W'(N - 1));

  // Accumulate the STEP bits currently sitting at the bottom of r_word.
  // For the leading/trailing modes the found flag is updated bit by bit so
  // a 1 part-way through a step stops counting for the remaining bits.
  always_comb begin
    w_acc_next   = r_acc;
    w_found_next = r_found;
    for (int k = 0; k < STEP; k++) begin
      case (r_mode)
        2'b00: begin
          if (!r_word[k]) w_acc_next = w_acc_next + ACC_W'(1);
        end
        2'b01: begin
          if (r_word[k]) w_acc_next = w_acc_next + ACC_W'(1);
        end
        default: begin
          if (!w_found_next) begin
            if (r_word[k]) w_found_next = 1'b1;
            else           w_acc_next   = w_acc_next + ACC_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_mode  <= 2'b00;
      r_acc   <= '0;
      r_found <= 1'b0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
            r_word  <= w_word_load;
            r_mode  <= i_mode;
            r_acc   <= '0;
            r_found <= 1'b0;
            r_step  <= '0;
          end
        end
        S_COUNT: begin
          r_acc   <= w_acc_next;
          r_found <= w_found_next;
          r_word  <= r_word >> STEP;
          r_step  <= r_step + CNT_W'(1);
          if (w_last_step) begin
            r_state            <= S_DONE;
            r_done             <= 1'b1;
            {r_carry, r_count} <= w_acc_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_count = r_count;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_bit_count_unit.sv
// -----------------------------------------------------------------------------
// tb_bit_count_unit
//
// Two instances: LEN=4/STEP=2 (u_dut0) and LEN=2/STEP=1 (u_dut1), both N=4.
// Expected results come from a reference function that scans the whole word
// directly; they are queued at start and compared when o_done is seen.
// -----------------------------------------------------------------------------
module tb_bit_count_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;

  logic       busy0, done0, carry0;
  logic [3:0] count0;
  logic       busy1, done1, carry1;
  logic [1:0] count1;

  int checks   = 0;
  int failures = 0;
  int q0[$];
  int q1[$];
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int e0, e1;
  int prev;

  bit_count_unit #(.LEN(4), .STEP(2)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start[0]),
    .i_mode  (mode),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy0),
    .o_done  (done0),
    .o_count (count0),
    .o_carry (carry0)
  );

  bit_count_unit #(.LEN(2), .STEP(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start[1]),
    .i_mode  (mode),
    .i_a     (a[1:0]),
    .i_b     (b[1:0]),
    .o_busy  (busy1),
    .o_done  (done1),
    .o_count (count1),
    .o_carry (carry1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct scan of the 2*len-bit word.
  function automatic int model(input int len, input logic [1:0] m, input logic [7:0] w);
    int cnt;
    cnt = 0;
    case (m)
      2'b00: for (int i = 0; i < 2*len; i++) if (w[i] == 1'b0) cnt++;
      2'b01: for (int i = 0; i < 2*len; i++) if (w[i] == 1'b1) cnt++;
      2'b10: begin
        for (int i = 2*len-1; i >= 0; i--) begin
          if (w[i]) break;
          cnt++;
        end
      end
      default: begin
        for (int i = 0; i < 2*len; i++) begin
          if (w[i]) break;
          cnt++;
        end
      end
    endcase
    return cnt;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done0) begin
      done_cnt0++;
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 32'(done0), 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_result", 32'({carry0, count0}), e0);
        $display("dut0 txn: result=%0d expected=%0d", {carry0, count0}, e0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_result", 32'({carry1, count1}), e1);
        $display("dut1 txn: result=%0d expected=%0d", {carry1, count1}, e1);
      end
    end
  end

  // One operation on instance d; checks latency, busy length and result hold.
  task automatic op(input int d, input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv);
    int         exp;
    int         dc;
    int         bc;
    logic [7:0] w;
    @(negedge clk);
    mode = m;
    a    = av;
    b    = bv;
    if (d == 0) begin
      w   = {av, bv};
      exp = model(4, m, w);
      q0.push_back(exp);
      start[0] = 1'b1;
    end else begin
      w   = {4'b0000, av[1:0], bv[1:0]};
      exp = model(2, m, w);
      q1.push_back(exp);
      start[1] = 1'b1;
    end
    dc = 0;
    bc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 2'b00;
      if ((d == 0) ? busy0 : busy1) bc++;
      else break;
      if (((d == 0) ? done0 : done1) && dc == 0) dc = c;
    end
    check("latency", 32'(dc), 32'd5);
    check("busy_cycles", 32'(bc), 32'd5);
    check("result_hold", (d == 0) ? 32'({carry0, count0}) : 32'({carry1, count1}), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 2'b00;
    mode  = 2'b00;
    a     = 4'h0;
    b     = 4'h0;
    #12;
    check("reset_dut0", 32'({busy0, done0, carry0, count0}), 32'd0);
    check("reset_dut1", 32'({busy1, done1, carry1, count1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, LEN=4 STEP=2
    op(0, 2'b00, 4'b0000, 4'b0000);   // 8
    op(0, 2'b01, 4'b1011, 4'b0001);   // 4
    op(0, 2'b10, 4'b0001, 4'b1111);   // 3
    op(0, 2'b11, 4'b1000, 4'b0100);   // 2
    op(0, 2'b11, 4'b0000, 4'b0000);   // 8
    op(0, 2'b10, 4'b0000, 4'b0000);   // 8
    op(0, 2'b01, 4'b0000, 4'b0000);   // 0
    op(0, 2'b10, 4'b1000, 4'b0000);   // 0
    op(0, 2'b11, 4'b0110, 4'b0001);   // 0
    op(0, 2'b01, 4'b1111, 4'b1111);   // 8

    // Directed cases, LEN=2 STEP=1
    op(1, 2'b00, 4'b0000, 4'b0000);   // 4 -> count 00, carry 1
    op(1, 2'b10, 4'b0001, 4'b0000);   // 1
    op(1, 2'b11, 4'b0010, 4'b0010);   // 1

    for (int i = 0; i < 12; i++) op(0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 6; i++)  op(1, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));

    // Start requests while busy, with changed operands, must be ignored
    @(negedge clk);
    mode = 2'b01; a = 4'b1011; b = 4'b0001;
    q0.push_back(4);
    prev = done_cnt0;
    start[0] = 1'b1;
    @(negedge clk);                    // COUNT cycle 1
    start = 2'b00;
    @(negedge clk);                    // COUNT cycle 2
    start[0] = 1'b1; mode = 2'b00; a = 4'hF; b = 4'hF;
    @(negedge clk);                    // COUNT cycle 3
    @(negedge clk);
    start = 2'b00;
    repeat (8) @(negedge clk);
    check("busy_single_done", 32'(done_cnt0 - prev), 32'd1);
    check("busy_idle_after", 32'(busy0), 32'd0);
    check("busy_result", 32'({carry0, count0}), 32'd4);

    // Reset in the middle of COUNT aborts with no done pulse
    @(negedge clk);
    mode = 2'b00; a = 4'h0; b = 4'h0;
    q0.push_back(8);
    prev = done_cnt0;
    start[0] = 1'b1;
    @(negedge clk);                    // COUNT cycle 1
    start = 2'b00;
    @(negedge clk);                    // COUNT cycle 2
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({busy0, done0, carry0, count0}), 32'd0);
    repeat (6) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt0 - prev), 32'd0);
    q0.delete();
    rst_n = 1'b1;
    op(0, 2'b01, 4'b0111, 4'b0110);   // 5
    op(0, 2'b11, 4'b0000, 4'b1000);   // 3

    repeat (3) @(negedge clk);
    check("queue0_drained", 32'(q0.size()), 32'd0);
    check("queue1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
